// File: rtl/jt900h_busarb_if.sv
// jt900h_busarb_if: CPU, micro-DMA and external memory signals around the bus arbiter.
// The master side is the arbiter itself; the slave side is the requesters plus the memory pins.
interface jt900h_busarb_if;
    logic        cen;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_dout;
    logic        cpu_ok;
    logic        dma_req;
    logic [23:0] dma_addr;
    logic [15:0] dma_din;
    logic [1:0]  dma_we;
    logic [15:0] dma_dout;
    logic        dma_ok;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_rd;
    logic [15:0] mem_dout;
    logic        mem_wait;
    logic        owner;
    logic        busy;

    modport master (
        input  cen, cpu_req, cpu_addr, cpu_din, cpu_we,
        input  dma_req, dma_addr, dma_din, dma_we, mem_dout, mem_wait,
        output cpu_dout, cpu_ok, dma_dout, dma_ok,
        output mem_addr, mem_din, mem_we, mem_rd, owner, busy
    );

    modport slave (
        output cen, cpu_req, cpu_addr, cpu_din, cpu_we,
        output dma_req, dma_addr, dma_din, dma_we, mem_dout, mem_wait,
        input  cpu_dout, cpu_ok, dma_dout, dma_ok,
        input  mem_addr, mem_din, mem_we, mem_rd, owner, busy
    );
endinterface

// File: rtl/jt900h_busarb.sv
// jt900h_busarb: shares the external 16-bit memory bus between the CPU and the micro-DMA,
// sequencing strobes for WAIT+1 enabled cycles and returning a one-cycle ok pulse.
module jt900h_busarb #(
    parameter int WAIT      = 1,
    parameter bit DMA_FIRST = 1
) (
    input logic             clk,
    input logic             rst,
    jt900h_busarb_if.master bus
);
    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [1:0]  we_q, we_d;
    logic        rd_q, rd_d;
    logic [15:0] cdout_q, cdout_d;
    logic [15:0] ddout_q, ddout_d;
    logic        cok_q, cok_d;
    logic        dok_q, dok_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        grant, grant_dma, finish;
    logic [23:0] sel_addr;
    logic [15:0] sel_din;
    logic [1:0]  sel_we;

    assign grant     = state_q == IDLE && (bus.cpu_req || bus.dma_req);
    // Under contention the side that did not complete last goes next
    assign grant_dma = (bus.cpu_req && bus.dma_req) ? ~last_q : bus.dma_req;
    assign finish    = state_q == ACCESS && cnt_q == 3'd0 && !bus.mem_wait;
    assign sel_addr  = grant_dma ? bus.dma_addr : bus.cpu_addr;
    assign sel_din   = grant_dma ? bus.dma_din : bus.cpu_din;
    assign sel_we    = grant_dma ? bus.dma_we : bus.cpu_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= '0;
            rd_q    <= 1'b0;
            cdout_q <= '0;
            ddout_q <= '0;
            cok_q   <= 1'b0;
            dok_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= ~DMA_FIRST;
        end else if (bus.cen) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            cdout_q <= cdout_d;
            ddout_q <= ddout_d;
            cok_q   <= cok_d;
            dok_q   <= dok_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE   ? (grant ? ACCESS : IDLE) :
                  state_q == ACCESS ? (finish ? DONE : ACCESS) : IDLE;
    end

    always_comb begin
        addr_d  = grant ? (sel_addr & 24'hFFFFFE) : addr_q;
        din_d   = grant ? sel_din : din_q;
        we_d    = grant ? sel_we : (finish ? 2'b00 : we_q);
        rd_d    = grant ? (sel_we == 2'b00) : (rd_q && !finish);
        cnt_d   = grant ? WAIT_CNT :
                  (state_q == ACCESS && !bus.mem_wait && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
        cok_d   = finish && !owner_q;
        dok_d   = finish && owner_q;
        cdout_d = (finish && rd_q && !owner_q) ? bus.mem_dout : cdout_q;
        ddout_d = (finish && rd_q && owner_q) ? bus.mem_dout : ddout_q;
        owner_d = grant ? grant_dma : owner_q;
        last_d  = finish ? owner_q : last_q;
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_rd   = rd_q;
    assign bus.cpu_dout = cdout_q;
    assign bus.dma_dout = ddout_q;
    assign bus.cpu_ok   = cok_q;
    assign bus.dma_ok   = dok_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_jt900h_busarb.sv
// tb_jt900h_busarb: directed and randomized transactions checked against a
// transaction-level model of grant order, access length and returned data.
module tb_jt900h_busarb;
    localparam int WAIT      = 1;
    localparam bit DMA_FIRST = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jt900h_busarb_if bus ();

    jt900h_busarb #(.WAIT(WAIT), .DMA_FIRST(DMA_FIRST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          cpend, dpend, last_dma, use_fix, cen_mode;
    logic [23:0] c_addr, d_addr;
    logic [15:0] c_din, d_din, exp_cdout, exp_ddout, last_md, fix_dout;
    logic [1:0]  c_we, d_we, e_we;
    logic        e_rd, e_cok, e_dok, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_bus(input logic rd, input logic [1:0] we, input logic cok, input logic dok,
                              input logic busy);
        e_rd = rd;
        e_we = we;
        e_cok = cok;
        e_dok = dok;
        e_busy = busy;
        chk("mem_rd", bus.mem_rd, rd);
        chk("mem_we", bus.mem_we, we);
        chk("cpu_ok", bus.cpu_ok, cok);
        chk("dma_ok", bus.dma_ok, dok);
        chk("busy", bus.busy, busy);
    endtask

    // One enabled cycle; in cen mode a disabled edge precedes it and must change nothing
    task automatic tick();
        if (cen_mode) begin
            bus.cen = 1'b0;
            bus.mem_dout = 16'($urandom);
            @(posedge clk);
            #1;
            expect_bus(e_rd, e_we, e_cok, e_dok, e_busy);
            chk("cpu_dout hold", bus.cpu_dout, exp_cdout);
            chk("dma_dout hold", bus.dma_dout, exp_ddout);
            bus.cen = 1'b1;
        end
        bus.mem_dout = use_fix ? fix_dout : 16'($urandom);
        last_md = bus.mem_dout;
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input bit dma);
        logic [1:0] we;
        we = ($urandom % 2) ? 2'b00 : 2'($urandom_range(1, 3));
        if (dma) begin
            dpend = 1'b1;
            d_addr = 24'($urandom);
            d_din = 16'($urandom);
            d_we = we;
        end else begin
            cpend = 1'b1;
            c_addr = 24'($urandom);
            c_din = 16'($urandom);
            c_we = we;
        end
    endtask

    task automatic drive();
        bus.cpu_req = cpend;
        bus.cpu_addr = c_addr;
        bus.cpu_din = c_din;
        bus.cpu_we = c_we;
        bus.dma_req = dpend;
        bus.dma_addr = d_addr;
        bus.dma_din = d_din;
        bus.dma_we = d_we;
    endtask

    // Full transaction from IDLE: grant, WAIT+1+stall strobe cycles, ok, turnaround
    task automatic access(input int stall, input bit keep);
        bit          win;
        int          n;
        logic [23:0] a;
        logic [15:0] d;
        logic [1:0]  we;
        win = (cpend && dpend) ? !last_dma : dpend;
        a = win ? d_addr : c_addr;
        d = win ? d_din : c_din;
        we = win ? d_we : c_we;
        drive();
        bus.mem_wait = 1'b0;
        tick();
        chk("owner", bus.owner, win);
        chk("mem_addr", bus.mem_addr, {a[23:1], 1'b0});
        chk("mem_din", bus.mem_din, d);
        expect_bus(we == 2'b00, we, 1'b0, 1'b0, 1'b1);
        n = WAIT + 1 + stall;
        for (int i = 1; i <= n; i++) begin
            bus.mem_wait = i > 1 && i <= stall + 1;
            tick();
            if (i < n) expect_bus(we == 2'b00, we, 1'b0, 1'b0, 1'b1);
        end
        bus.mem_wait = 1'b0;
        if (we == 2'b00) begin
            if (win) exp_ddout = last_md;
            else exp_cdout = last_md;
        end
        expect_bus(1'b0, 2'b00, !win, win, 1'b1);
        chk("cpu_dout", bus.cpu_dout, exp_cdout);
        chk("dma_dout", bus.dma_dout, exp_ddout);
        last_dma = win;
        if (win) dpend = 1'b0;
        else cpend = 1'b0;
        if (keep) new_req(win);
        drive();
        tick();
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cen = 1'b1;
        bus.mem_wait = 1'b0;
        bus.mem_dout = '0;
        cpend = 0;
        dpend = 0;
        c_addr = '0;
        d_addr = '0;
        c_din = '0;
        d_din = '0;
        c_we = '0;
        d_we = '0;
        use_fix = 0;
        cen_mode = 0;
        fix_dout = '0;
        drive();
        exp_cdout = '0;
        exp_ddout = '0;
        last_dma = !DMA_FIRST;
        #12;
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_din", bus.mem_din, 0);
        chk("rst owner", bus.owner, 0);
        chk("rst cpu_dout", bus.cpu_dout, 0);
        chk("rst dma_dout", bus.dma_dout, 0);
        #10 rst = 1'b0;
        tick();
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Contention from reset: DMA, CPU, DMA, CPU, then the leftover DMA
        new_req(0);
        new_req(1);
        access(0, 1);
        access(0, 1);
        access(0, 1);
        access(0, 0);
        access(0, 0);

        cpend = 1;
        c_addr = 24'h001235;
        c_din = 16'h0000;
        c_we = 2'b00;
        use_fix = 1;
        fix_dout = 16'hBEEF;
        access(0, 0);
        use_fix = 0;
        chk("cpu read data", bus.cpu_dout, 16'hBEEF);

        dpend = 1;
        d_addr = 24'h000100;
        d_din = 16'h55AA;
        d_we = 2'b01;
        access(0, 0);

        new_req(0);
        c_we = 2'b00;
        access(3, 0);

        cen_mode = 1;
        new_req(0);
        c_we = 2'b00;
        access(0, 0);
        cen_mode = 0;

        // Asynchronous reset mid-access, with the DMA request still pending
        new_req(1);
        d_we = 2'b00;
        drive();
        tick();
        expect_bus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("owner pre-rst", bus.owner, 1);
        tick();
        expect_bus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        exp_cdout = '0;
        exp_ddout = '0;
        last_dma = !DMA_FIRST;
        #1;
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("owner rst", bus.owner, 0);
        chk("dma_dout rst", bus.dma_dout, 0);
        #2 rst = 1'b0;
        tick();
        expect_bus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("regrant owner", bus.owner, 1);
        chk("regrant addr", bus.mem_addr, {d_addr[23:1], 1'b0});
        for (int i = 1; i <= WAIT + 1; i++) tick();
        exp_ddout = last_md;
        expect_bus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("regrant data", bus.dma_dout, exp_ddout);
        dpend = 0;
        last_dma = 1;
        drive();
        tick();
        expect_bus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if (!cpend && ($urandom % 2)) new_req(0);
            if (!dpend && ($urandom % 2)) new_req(1);
            if (!cpend && !dpend) new_req(1'($urandom % 2));
            cen_mode = ($urandom % 4) == 0;
            access(int'($urandom % 4), 0);
        end
        cen_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
